// File: rtl/ht_task_arbiter_pkg.sv
// Shared hash-table command/result types plus the round-robin grant helper
// used by the task arbiter.
package ht_task_arbiter_pkg;

  typedef enum logic [1:0] {
    HT_CMD_SEARCH = 2'd0,
    HT_CMD_INSERT = 2'd1,
    HT_CMD_DELETE = 2'd2,
    HT_CMD_NOP    = 2'd3
  } ht_cmd_t;

  typedef enum logic [2:0] {
    HT_RES_FOUND      = 3'd0,
    HT_RES_NOT_FOUND  = 3'd1,
    HT_RES_INSERTED   = 3'd2,
    HT_RES_TABLE_FULL = 3'd3,
    HT_RES_DELETED    = 3'd4,
    HT_RES_ERROR      = 3'd5
  } ht_rescode_t;

  localparam int unsigned RR_MAX_REQ = 8;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } rr_grant_t;

  // First valid requester at or after ptr, wrapping within num_req.
  function automatic rr_grant_t rr_next_grant(input logic [RR_MAX_REQ-1:0] valid,
                                              input logic [2:0]            ptr,
                                              input int unsigned           num_req);
    rr_grant_t   g;
    int unsigned idx;
    g = '0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % num_req;
      if ((k < num_req) && !g.hit && valid[idx]) begin
        g.hit = 1'b1;
        g.idx = 3'(idx);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ht_task_arbiter_tag.sv
// In-order tag FIFO recording which requester owns each outstanding task.
module ht_tag_fifo
  import ht_task_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [TAG_W-1:0]         push_tag_i,
  input  logic                     pop_i,
  output logic [TAG_W-1:0]         head_tag_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + PTR_W'(1);
    if (pop_i)  rd_d = rd_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= push_tag_i;
  end

  assign head_tag_o = mem_q[rd_q];
  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;

endmodule

// File: rtl/ht_task_arbiter.sv
// Round-robin sharing of one hash_table_top task port among NUM_REQ clients,
// with in-order routing of results back to the issuing client.
module ht_task_arbiter
  import ht_task_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned KEY_WIDTH    = 32,
  parameter int unsigned VALUE_WIDTH  = 16,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]     req_key_i,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0]   req_value_i,
  input  ht_cmd_t [NUM_REQ-1:0]            req_cmd_i,
  output logic                             ht_task_valid_o,
  input  logic                             ht_task_ready_i,
  output logic [KEY_WIDTH-1:0]             ht_task_key_o,
  output logic [VALUE_WIDTH-1:0]           ht_task_value_o,
  output ht_cmd_t                          ht_task_cmd_o,
  input  logic                             ht_res_valid_i,
  output logic                             ht_res_ready_o,
  input  logic [KEY_WIDTH-1:0]             ht_res_key_i,
  input  logic [VALUE_WIDTH-1:0]           ht_res_value_i,
  input  ht_cmd_t                          ht_res_cmd_i,
  input  ht_rescode_t                      ht_res_rescode_i,
  output logic [NUM_REQ-1:0]               res_valid_o,
  input  logic [NUM_REQ-1:0]               res_ready_i,
  output logic [KEY_WIDTH-1:0]             res_key_o,
  output logic [VALUE_WIDTH-1:0]           res_value_o,
  output ht_cmd_t                          res_cmd_o,
  output ht_rescode_t                      res_rescode_o,
  output logic [$clog2(MAX_INFLIGHT):0]    inflight_o,
  output logic                             orphan_res_o
);

  localparam int unsigned TAG_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0]       ptr_q, ptr_d;
  logic                   task_valid_q, task_valid_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  ht_cmd_t                cmd_q, cmd_d;
  logic                   orphan_q;

  logic [RR_MAX_REQ-1:0]  valid_ext;
  rr_grant_t              grant;
  logic [TAG_W-1:0]       gidx;
  logic                   stage_free, accept;

  logic [TAG_W-1:0]       head_tag;
  logic                   fifo_full, fifo_empty, pop;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid_i;
    grant                    = rr_next_grant(valid_ext, 3'(ptr_q), NUM_REQ);
  end

  assign gidx       = TAG_W'(grant.idx);
  assign stage_free = !task_valid_q || ht_task_ready_i;
  // Full is the registered count, so a same-cycle pop never frees a slot early.
  assign accept     = stage_free && !fifo_full && grant.hit && !rst_i;

  always_comb begin
    req_ready_o  = '0;
    task_valid_d = task_valid_q;
    key_d        = key_q;
    value_d      = value_q;
    cmd_d        = cmd_q;
    ptr_d        = ptr_q;
    if (accept) begin
      req_ready_o[gidx] = 1'b1;
      task_valid_d      = 1'b1;
      key_d             = req_key_i[gidx*KEY_WIDTH +: KEY_WIDTH];
      value_d           = req_value_i[gidx*VALUE_WIDTH +: VALUE_WIDTH];
      cmd_d             = req_cmd_i[gidx];
      ptr_d             = (gidx == TAG_W'(NUM_REQ - 1)) ? '0 : gidx + TAG_W'(1);
    end else if (ht_task_ready_i) begin
      task_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      task_valid_q <= 1'b0;
      key_q        <= '0;
      value_q      <= '0;
      cmd_q        <= HT_CMD_SEARCH;
      orphan_q     <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      task_valid_q <= task_valid_d;
      key_q        <= key_d;
      value_q      <= value_d;
      cmd_q        <= cmd_d;
      orphan_q     <= ht_res_valid_i && fifo_empty;
    end
  end

  // With no owner on record the result is swallowed and flagged as an orphan.
  always_comb begin
    res_valid_o    = '0;
    ht_res_ready_o = 1'b1;
    pop            = 1'b0;
    if (!fifo_empty) begin
      ht_res_ready_o = res_ready_i[head_tag];
      if (ht_res_valid_i) res_valid_o[head_tag] = 1'b1;
      pop = ht_res_valid_i && res_ready_i[head_tag];
    end
  end

  ht_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (accept),
    .push_tag_i (gidx),
    .pop_i      (pop),
    .head_tag_o (head_tag),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (inflight_o)
  );

  assign ht_task_valid_o = task_valid_q;
  assign ht_task_key_o   = key_q;
  assign ht_task_value_o = value_q;
  assign ht_task_cmd_o   = cmd_q;
  assign res_key_o       = ht_res_key_i;
  assign res_value_o     = ht_res_value_i;
  assign res_cmd_o       = ht_res_cmd_i;
  assign res_rescode_o   = ht_res_rescode_i;
  assign orphan_res_o    = orphan_q;

endmodule

// File: tb/tb_ht_task_arbiter.sv
// Self-checking bench for ht_task_arbiter: grant table, scoreboarded task and
// result paths, and hand-written stall/full/orphan/reset sequences.
module tb_ht_task_arbiter;
  import ht_task_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned KW = 32;
  localparam int unsigned VW = 16;
  localparam int unsigned MI = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, res_valid, res_ready;
  logic [NR*KW-1:0]  req_key;
  logic [NR*VW-1:0]  req_value;
  ht_cmd_t [NR-1:0]  req_cmd;
  logic              ht_task_valid, ht_task_ready, ht_res_valid, ht_res_ready;
  logic [KW-1:0]     ht_task_key, ht_res_key, res_key;
  logic [VW-1:0]     ht_task_value, ht_res_value, res_value;
  ht_cmd_t           ht_task_cmd, ht_res_cmd, res_cmd;
  ht_rescode_t       ht_res_rescode, res_rescode;
  logic [3:0]        inflight;
  logic              orphan;

  always #5 clk = ~clk;

  ht_task_arbiter #(
    .NUM_REQ      (NR),
    .KEY_WIDTH    (KW),
    .VALUE_WIDTH  (VW),
    .MAX_INFLIGHT (MI)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_key_i        (req_key),
    .req_value_i      (req_value),
    .req_cmd_i        (req_cmd),
    .ht_task_valid_o  (ht_task_valid),
    .ht_task_ready_i  (ht_task_ready),
    .ht_task_key_o    (ht_task_key),
    .ht_task_value_o  (ht_task_value),
    .ht_task_cmd_o    (ht_task_cmd),
    .ht_res_valid_i   (ht_res_valid),
    .ht_res_ready_o   (ht_res_ready),
    .ht_res_key_i     (ht_res_key),
    .ht_res_value_i   (ht_res_value),
    .ht_res_cmd_i     (ht_res_cmd),
    .ht_res_rescode_i (ht_res_rescode),
    .res_valid_o      (res_valid),
    .res_ready_i      (res_ready),
    .res_key_o        (res_key),
    .res_value_o      (res_value),
    .res_cmd_o        (res_cmd),
    .res_rescode_o    (res_rescode),
    .inflight_o       (inflight),
    .orphan_res_o     (orphan)
  );

  typedef struct {
    int unsigned tag;
    logic [KW-1:0] key;
    logic [VW-1:0] value;
    ht_cmd_t       cmd;
  } tsk_t;

  typedef struct {
    logic [NR-1:0] vld;
    logic [NR-1:0] exp_rdy;
  } vec_t;

  tsk_t exp_q[$];
  tsk_t ht_q[$];
  vec_t tbl[12];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   n_issue = 0;
  bit   auto_res = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [KW-1:0] key,
                         input logic [VW-1:0] val, input ht_cmd_t cmd);
    req_key[i*KW +: KW]   = key;
    req_value[i*VW +: VW] = val;
    req_cmd[i]            = cmd;
  endtask

  task automatic drive_res();
    if (ht_q.size() > 0) begin
      ht_res_valid   = 1'b1;
      ht_res_key     = ht_q[0].key;
      ht_res_value   = ht_q[0].value ^ 16'h5A5A;
      ht_res_cmd     = ht_q[0].cmd;
      ht_res_rescode = HT_RES_FOUND;
    end else begin
      ht_res_valid = 1'b0;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Record handshakes for the coming edge, then advance one clock.
  task automatic tick();
    tsk_t t;
    #1;
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        t.tag   = i;
        t.key   = req_key[i*KW +: KW];
        t.value = req_value[i*VW +: VW];
        t.cmd   = req_cmd[i];
        exp_q.push_back(t);
      end
    end
    if (ht_task_valid && ht_task_ready) begin
      n_issue++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL task_unexpected: actual key=%0h required=none", ht_task_key);
      end else begin
        t = exp_q.pop_front();
        check("task_key", ht_task_key, t.key);
        check("task_value", 32'(ht_task_value), 32'(t.value));
        check("task_cmd", 32'(ht_task_cmd), 32'(t.cmd));
        ht_q.push_back(t);
      end
    end
    if (ht_res_valid && ht_res_ready && ht_q.size() > 0) begin
      t = ht_q.pop_front();
      check("res_onehot", 32'(res_valid), 32'(1) << t.tag);
      check("res_key", res_key, t.key);
      check("res_value", 32'(res_value), 32'(t.value ^ 16'h5A5A));
    end
    @(posedge clk);
    #1;
    if (auto_res) drive_res();
  endtask

  task automatic drain();
    req_valid     = '0;
    ht_task_ready = 1'b1;
    res_ready     = '1;
    auto_res      = 1'b1;
    drive_res();
    for (int k = 0; k < 40 && (ht_q.size() > 0 || exp_q.size() > 0 || ht_task_valid); k++) tick();
    check("drain_inflight", 32'(inflight), 32'd0);
    check("drain_pending", 32'(ht_q.size() + exp_q.size()), 32'd0);
    auto_res     = 1'b0;
    ht_res_valid = 1'b0;
  endtask

  int unsigned issue0;

  initial begin
    tbl[0]  = '{4'b1111, 4'b1000};
    tbl[1]  = '{4'b1111, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b0010};
    tbl[3]  = '{4'b1111, 4'b0100};
    tbl[4]  = '{4'b1111, 4'b1000};
    tbl[5]  = '{4'b0110, 4'b0010};
    tbl[6]  = '{4'b0110, 4'b0100};
    tbl[7]  = '{4'b0011, 4'b0001};
    tbl[8]  = '{4'b0000, 4'b0000};
    tbl[9]  = '{4'b1001, 4'b1000};
    tbl[10] = '{4'b1001, 4'b0001};
    tbl[11] = '{4'b0001, 4'b0001};

    rst = 1'b1;
    req_valid = 4'b1111; req_key = '0; req_value = '0;
    for (int i = 0; i < NR; i++) req_cmd[i] = HT_CMD_SEARCH;
    ht_task_ready = 1'b0; ht_res_valid = 1'b0; res_ready = '0;
    ht_res_key = '0; ht_res_value = '0; ht_res_cmd = HT_CMD_SEARCH; ht_res_rescode = HT_RES_FOUND;
    #12;
    check("rst_task_valid", 32'(ht_task_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_orphan", 32'(orphan), 32'd0);
    check("rst_task_key", ht_task_key, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single requester
    req_valid = 4'b0100; ht_task_ready = 1'b1; res_ready = '1;
    set_req(2, 32'h02000000, 16'h1234, HT_CMD_INSERT);
    settle();
    check("t1_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    check("t1_task_valid", 32'(ht_task_valid), 32'd1);
    check("t1_task_key", ht_task_key, 32'h02000000);
    check("t1_inflight1", 32'(inflight), 32'd1);
    tick();
    check("t1_task_idle", 32'(ht_task_valid), 32'd0);
    drive_res();
    settle();
    check("t1_res_valid", 32'(res_valid), 32'b0100);
    check("t1_ht_res_ready", 32'(ht_res_ready), 32'd1);
    tick();
    drive_res();
    settle();
    check("t1_inflight0", 32'(inflight), 32'd0);

    // round-robin table, pointer starts after requester 2
    auto_res = 1'b1;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NR; i++)
        set_req(i, {8'(i), 8'(r), 16'h0}, 16'(r * 16 + i), ht_cmd_t'(2'(i)));
      req_valid = tbl[r].vld;
      settle();
      check($sformatf("rr_grant_%0d", r), 32'(req_ready), 32'(tbl[r].exp_rdy));
      tick();
    end
    drain();

    // task stall with ht_task_ready low, pointer at 1
    ht_task_ready = 1'b0;
    req_valid = 4'b0001;
    set_req(0, 32'hC0DE0000, 16'h0C0D, HT_CMD_DELETE);
    set_req(1, 32'hC0DE0001, 16'h0C0E, HT_CMD_SEARCH);
    settle();
    check("t3_first_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("t3_no_grant", 32'(req_ready), 32'd0);
      check("t3_hold_valid", 32'(ht_task_valid), 32'd1);
      check("t3_hold_key", ht_task_key, 32'hC0DE0000);
      tick();
    end
    req_valid = '0;
    issue0 = n_issue;
    ht_task_ready = 1'b1;
    tick(); tick(); tick();
    check("t3_one_issue", n_issue - issue0, 32'd1);
    check("t3_idle", 32'(ht_task_valid), 32'd0);
    drain();

    // fill to MAX_INFLIGHT, pointer at 1
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) set_req(i, {8'hF0 + 8'(i), 24'(k)}, 16'(k), HT_CMD_INSERT);
      settle();
      check($sformatf("t4_fill_%0d", k), 32'(req_ready), 32'(1) << ((1 + k) % 4));
      tick();
    end
    settle();
    check("t4_inflight_full", 32'(inflight), 32'd8);
    check("t4_full_no_grant", 32'(req_ready), 32'd0);
    tick();
    drive_res();
    settle();
    check("t4_pop_no_grant", 32'(req_ready), 32'd0);
    check("t4_pop_res_valid", 32'(res_valid), 32'b0010);
    check("t4_pop_ready", 32'(ht_res_ready), 32'd1);
    tick();
    ht_res_valid = 1'b0;
    settle();
    check("t4_inflight_7", 32'(inflight), 32'd7);
    check("t4_grant_after", 32'(req_ready), 32'b0010);
    tick();
    drain();

    // head owner back-pressure, pointer at 2
    req_valid = 4'b0101;
    set_req(0, 32'hAAAA0000, 16'h0A00, HT_CMD_SEARCH);
    set_req(2, 32'hAAAA0002, 16'h0A02, HT_CMD_INSERT);
    settle();
    check("t5_grant2", 32'(req_ready), 32'b0100);
    tick();
    settle();
    check("t5_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick(); tick();
    res_ready = 4'b1011;
    drive_res();
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t5_stall_ready", 32'(ht_res_ready), 32'd0);
      check("t5_stall_valid", 32'(res_valid), 32'b0100);
      check("t5_stall_inflight", 32'(inflight), 32'd2);
      tick();
    end
    res_ready = '1;
    settle();
    check("t5_release_ready", 32'(ht_res_ready), 32'd1);
    tick();
    drive_res();
    settle();
    check("t5_second_owner", 32'(res_valid), 32'b0001);
    tick();
    drive_res();
    settle();
    check("t5_inflight0", 32'(inflight), 32'd0);

    // orphan result
    ht_res_valid = 1'b1; ht_res_key = 32'hDEAD0000;
    settle();
    check("t6_orphan_ready", 32'(ht_res_ready), 32'd1);
    check("t6_orphan_no_valid", 32'(res_valid), 32'd0);
    tick();
    ht_res_valid = 1'b0;
    settle();
    check("t6_orphan_pulse", 32'(orphan), 32'd1);
    tick();
    check("t6_orphan_clear", 32'(orphan), 32'd0);

    // asynchronous reset mid-burst
    auto_res = 1'b1;
    req_valid = 4'b1111;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    auto_res = 1'b0;
    ht_res_valid = 1'b0;
    #1;
    check("t6_rst_task_valid", 32'(ht_task_valid), 32'd0);
    check("t6_rst_req_ready", 32'(req_ready), 32'd0);
    check("t6_rst_res_valid", 32'(res_valid), 32'd0);
    check("t6_rst_inflight", 32'(inflight), 32'd0);
    check("t6_rst_key", ht_task_key, 32'd0);
    exp_q.delete();
    ht_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b0110;
    settle();
    check("t6_post_rst_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    check("t6_post_rst_issue", 32'(ht_task_valid), 32'd1);
    check("t6_post_rst_key", ht_task_key, req_key[1*KW +: KW]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ht_task_arbiter.md
Name: ht_task_arbiter

Overview:
- Shares one hash_table_top task input among NUM_REQ independent requesters using round-robin arbitration.
- Routes each hash table result back to the requester that issued the task, via an in-order tag FIFO.
- Sits between client logic (for example, packet-parser lookup ports) and the ht_task_in / ht_res_out ports of hash_table_top.
- hash_table_top returns results strictly in task-acceptance order.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- KEY_WIDTH, 32, key width.
- VALUE_WIDTH, 16, value width.
- MAX_INFLIGHT, 8, depth of the tag FIFO; maximum number of tasks without a result (power of 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  NUM_REQ  per-requester task valid.
- req_ready_o  out  NUM_REQ  per-requester task accepted.
- req_key_i  in  NUM_REQ*KEY_WIDTH  packed keys; requester i in slice i.
- req_value_i  in  NUM_REQ*VALUE_WIDTH  packed values.
- req_cmd_i  in  NUM_REQ x ht_cmd_t  packed commands.
- ht_task_valid_o  out  1  task valid to hash table.
- ht_task_ready_i  in  1  hash table accepts task.
- ht_task_key_o / ht_task_value_o / ht_task_cmd_o  out  KEY_WIDTH / VALUE_WIDTH / ht_cmd_t  task payload.
- ht_res_valid_i  in  1  result valid from hash table.
- ht_res_ready_o  out  1  result accepted.
- ht_res_key_i / ht_res_value_i / ht_res_cmd_i / ht_res_rescode_i  in  payload  result fields (rescode is ht_rescode_t).
- res_valid_o  out  NUM_REQ  one-hot result valid to the owning requester.
- res_ready_i  in  NUM_REQ  per-requester result ready.
- res_key_o / res_value_o / res_cmd_o / res_rescode_o  out  payload  result broadcast to all requesters; qualified by res_valid_o.
- inflight_o  out  $clog2(MAX_INFLIGHT)+1  current FIFO occupancy.
- orphan_res_o  out  1  one-cycle pulse when a result arrives with the FIFO empty.

Behaviour:
- Reset values: ht_task_valid_o=0, req_ready_o=0, res_valid_o=0, inflight_o=0, orphan_res_o=0, priority pointer=0, FIFO empty. Payload outputs reset to 0.
- Output stage is a single register; the stage is free when !ht_task_valid_o or ht_task_ready_i.
- Arbitration runs each cycle when the stage is free and the FIFO is not full:
  - Grant goes to the first valid requester at or after the pointer, scanning upward with wrap.
  - req_ready_o is one-hot on the granted requester, combinational in the same cycle.
- Accept on req_valid_i[g] & req_ready_o[g]:
  - Payload loads into the output stage next edge; ht_task_valid_o=1. Latency is 1 cycle.
  - g is pushed into the tag FIFO.
  - Pointer becomes (g+1) mod NUM_REQ.
- ht_task_valid_o and payload hold stable until ht_task_ready_i. Back-to-back issue is allowed (one task per cycle at full throughput).
- Pointer holds when there is no grant.
- FIFO full (inflight_o==MAX_INFLIGHT): no grant, even if a pop occurs in the same cycle. This is a registered full decision.
- Result path when FIFO non-empty with head tag h:
  - res_valid_o = ht_res_valid_i << h.
  - ht_res_ready_o = res_ready_i[h].
  - Result payload passes through combinationally (zero latency).
  - Pop on ht_res_valid_i & ht_res_ready_o.
- Result path when FIFO empty:
  - ht_res_ready_o=1 and the result is dropped.
  - orphan_res_o pulses on the following edge.
  - res_valid_o stays 0.
- Push and pop in the same cycle: inflight_o unchanged; FIFO pointers wrap mod MAX_INFLIGHT.
- inflight_o counts from accept (into the output stage) to the result handshake.
- Reset asserted mid-operation: all state clears immediately, and tasks/results in flight are discarded. Requesters must reissue.

Decomposition:
- The hash_table package supplies ht_cmd_t and ht_rescode_t, and gains a function for the round-robin next-grant (valid vector, pointer).
- Sub-module ht_tag_fifo: synchronous FIFO of $clog2(NUM_REQ)-bit tags, depth MAX_INFLIGHT, with full, empty and count outputs.

Test Plan:
1. Single requester: req 2 sends key 32'h02000000, INSERT; ht_task_ready_i=1.
   -> ht_task_valid_o is high exactly 1 cycle after accept with that key.
   -> Result later returns with res_valid_o=4'b0100 and inflight_o goes 1 -> 0.
2. All four requesters valid continuously, ht_task_ready_i=1.
   -> Grants follow 0,1,2,3,0,...
   -> Tasks issue one per cycle.
   -> Results return with res_valid_o walking 0001,0010,0100,1000.
3. ht_task_ready_i=0 for 5 cycles while a task is pending.
   -> Payload stays stable.
   -> No further req_ready_o.
   -> Exactly one issue occurs after ready rises.
4. Hold results back until 8 tasks are issued.
   -> inflight_o=8 and req_ready_o=0.
   -> A result pop in the same cycle still gives no grant; a grant follows the next cycle.
5. Head owner res_ready_i=0 for 3 cycles.
   -> ht_res_ready_o=0 and results stall.
   -> A different requester's ready has no effect.
6. Inject a result with the FIFO empty.
   -> orphan_res_o pulses once and res_valid_o stays 0.
   -> Then assert rst_i mid-burst; all outputs return to reset values asynchronously.
